// File: rtl/image_pkt_pkg.sv
// Shared types and constants for the image packet deframer.
package image_pkt_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    SYNC_B  = 3'd1,
    LEN_H   = 3'd2,
    LEN_L   = 3'd3,
    CHK_H   = 3'd4,
    CHK_L   = 3'd5,
    PAYLOAD = 3'd6
  } state_t;

  localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

  // sync(2) + length(2) + checksum(2)
  localparam int HDR_BYTES = 6;

endpackage

// File: rtl/pkt_checksum16.sv
// Running 16-bit byte-sum accumulator with a look-ahead of the next sum.
import image_pkt_pkg::*;

module pkt_checksum16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        acc_en,
  input  logic [7:0]  data,
  output logic [15:0] sum,
  output logic [15:0] sum_nxt
);

  assign sum_nxt = sum + {8'h00, data};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sum <= 16'h0000;
    end else if (clr) begin
      sum <= 16'h0000;
    end else if (acc_en) begin
      sum <= sum_nxt;
    end
  end

endmodule

// File: rtl/image_pkt_deframer.sv
// Sync-word hunting byte-stream deframer with payload checksum check.
// Optional inter-byte timeout enabled by defining DEFRAMER_TIMEOUT_EN.
//
// state   | meaning
// HUNT    | waiting for first sync byte
// SYNC_B  | first sync byte seen, expecting second
// LEN_H   | expecting payload length high byte
// LEN_L   | expecting payload length low byte, length checked here
// CHK_H   | expecting header checksum high byte
// CHK_L   | expecting header checksum low byte
// PAYLOAD | forwarding payload bytes until length reached
import image_pkt_pkg::*;

module image_pkt_deframer #(
  parameter int         MAX_LEN     = 4096,
  parameter logic [7:0] SYNC0       = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1       = SYNC1_DEFAULT,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic [7:0]  received_data,
  output logic        dataRdy,
  output logic        strb,
  output logic [15:0] header_image_data_checksum,
  output logic        chk_ok,
  output logic        chk_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

  state_t      state, state_nxt;
  logic [7:0]  len_hi;
  logic [7:0]  chk_hi;
  logic [15:0] pay_len;
  logic [15:0] byte_cnt;
  logic [15:0] hdr_chk;
  logic [15:0] csum;
  logic [15:0] csum_nxt;
  logic [15:0] len_full;
  logic        len_bad;
  logic        last_byte;
  logic        chk_match;
  logic        timeout;
  logic        dr_d, strb_d, ok_d, err_d;
  logic        csum_clr;

  assign len_full = {len_hi, in_byte};
  assign header_image_data_checksum = hdr_chk;

  always_comb begin
    len_bad   = (len_full == 16'h0000) || ({1'b0, len_full} > MAX_LEN_W);
    last_byte = in_valid && (state == PAYLOAD) && ((byte_cnt + 16'd1) == pay_len);
    chk_match = (csum_nxt == hdr_chk);
    csum_clr  = in_valid && (state == CHK_L);
  end

`ifdef DEFRAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC);

  logic [TW-1:0] idle_cnt;

  // Down-counter reloads on every accepted byte; terminal count of 1 marks
  // the TIMEOUT_CYC-th consecutive idle cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt <= TO_LOAD;
    end else if (in_valid || (state == HUNT)) begin
      idle_cnt <= TO_LOAD;
    end else if (idle_cnt != TW'(1)) begin
      idle_cnt <= idle_cnt - TW'(1);
    end
  end

  assign timeout = !in_valid && (state != HUNT) && (idle_cnt == TW'(1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = HUNT;
    end else if (in_valid) begin
      case (state)
        HUNT:    if (in_byte == SYNC0) state_nxt = SYNC_B;
        SYNC_B: begin
          if (in_byte == SYNC1)      state_nxt = LEN_H;
          else if (in_byte == SYNC0) state_nxt = SYNC_B;
          else                       state_nxt = HUNT;
        end
        LEN_H:   state_nxt = LEN_L;
        LEN_L:   state_nxt = len_bad ? HUNT : CHK_H;
        CHK_H:   state_nxt = CHK_L;
        CHK_L:   state_nxt = PAYLOAD;
        PAYLOAD: state_nxt = last_byte ? HUNT : PAYLOAD;
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    dr_d   = in_valid && (state == PAYLOAD);
    strb_d = last_byte;
    ok_d   = last_byte && chk_match;
    err_d  = (last_byte && !chk_match)
          || (in_valid && (state == LEN_L) && len_bad)
          || timeout;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      received_data <= 8'h00;
      dataRdy       <= 1'b0;
      strb          <= 1'b0;
      chk_ok        <= 1'b0;
      chk_err       <= 1'b0;
      frame_cnt     <= 16'h0000;
      err_cnt       <= 16'h0000;
      len_hi        <= 8'h00;
      chk_hi        <= 8'h00;
      pay_len       <= 16'h0000;
      byte_cnt      <= 16'h0000;
      hdr_chk       <= 16'h0000;
    end else begin
      dataRdy <= dr_d;
      strb    <= strb_d;
      chk_ok  <= ok_d;
      chk_err <= err_d;
      if (dr_d) received_data <= in_byte;
      if (ok_d) frame_cnt <= frame_cnt + 16'd1;
      if (err_d) err_cnt <= err_cnt + 16'd1;
      if (in_valid) begin
        case (state)
          LEN_H:   len_hi <= in_byte;
          LEN_L:   pay_len <= len_full;
          CHK_H:   chk_hi <= in_byte;
          CHK_L: begin
            hdr_chk  <= {chk_hi, in_byte};
            byte_cnt <= 16'h0000;
          end
          PAYLOAD: byte_cnt <= byte_cnt + 16'd1;
          default: ;
        endcase
      end
    end
  end

  pkt_checksum16 u_checksum (
    .clk     (clk),
    .rst     (rst),
    .clr     (csum_clr),
    .acc_en  (dr_d),
    .data    (in_byte),
    .sum     (csum),
    .sum_nxt (csum_nxt)
  );

endmodule

// File: tb/tb_image_pkt_deframer.sv
// Directed self-checking bench for image_pkt_deframer.
import image_pkt_pkg::*;

module tb_image_pkt_deframer;

  logic        clk;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic [7:0]  received_data;
  logic        dataRdy;
  logic        strb;
  logic [15:0] header_image_data_checksum;
  logic        chk_ok;
  logic        chk_err;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int tests = 0;
  int fails = 0;
  int dr_seen = 0;
  int dr_mark;
  int hdr_sent = 0;

  image_pkt_deframer dut (
    .clk                        (clk),
    .rst                        (rst),
    .in_byte                    (in_byte),
    .in_valid                   (in_valid),
    .received_data              (received_data),
    .dataRdy                    (dataRdy),
    .strb                       (strb),
    .header_image_data_checksum (header_image_data_checksum),
    .chk_ok                     (chk_ok),
    .chk_err                    (chk_err),
    .frame_cnt                  (frame_cnt),
    .err_cnt                    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (dataRdy === 1'b1) dr_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (dataRdy === 1'b1) dr_seen++;
    end
  endtask

  task automatic header(input logic [15:0] len, input logic [15:0] cs);
    send(8'hA5);
    send(8'h5A);
    send(len[15:8]);
    send(len[7:0]);
    send(cs[15:8]);
    send(cs[7:0]);
    hdr_sent += HDR_BYTES;
  endtask

  task automatic pay(input string tag, input logic [7:0] b, input logic s,
                     input logic ok, input logic err);
    send(b);
    chk({tag, "_rdy"},  {31'd0, dataRdy}, 32'd1);
    chk({tag, "_data"}, {24'd0, received_data}, {24'd0, b});
    chk({tag, "_strb"}, {31'd0, strb}, {31'd0, s});
    chk({tag, "_ok"},   {31'd0, chk_ok}, {31'd0, ok});
    chk({tag, "_err"},  {31'd0, chk_err}, {31'd0, err});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, {24'd0, received_data}, 32'd0);
    chk({tag, "_rdy"},  {31'd0, dataRdy}, 32'd0);
    chk({tag, "_strb"}, {31'd0, strb}, 32'd0);
    chk({tag, "_ok"},   {31'd0, chk_ok}, 32'd0);
    chk({tag, "_err"},  {31'd0, chk_err}, 32'd0);
    chk({tag, "_hdr"},  {16'd0, header_image_data_checksum}, 32'd0);
    chk({tag, "_fcnt"}, {16'd0, frame_cnt}, 32'd0);
    chk({tag, "_ecnt"}, {16'd0, err_cnt}, 32'd0);
  endtask

  task automatic good_frame(input string tag);
    header(16'h0003, 16'h0006);
    pay({tag, "_b1"}, 8'h01, 1'b0, 1'b0, 1'b0);
    pay({tag, "_b2"}, 8'h02, 1'b0, 1'b0, 1'b0);
    pay({tag, "_b3"}, 8'h03, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    rst      = 1'b0;
    in_byte  = 8'h00;
    in_valid = 1'b0;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b1;
    idle(2);

    // good frame
    good_frame("good");
    chk("good_hdr",  {16'd0, header_image_data_checksum}, 32'h0006);
    chk("good_fcnt", {16'd0, frame_cnt}, 32'd1);
    chk("good_ecnt", {16'd0, err_cnt}, 32'd0);
    chk("good_drcnt", dr_seen, 32'd3);
    idle(1);
    chk("good_pulse_rdy",  {31'd0, dataRdy}, 32'd0);
    chk("good_pulse_strb", {31'd0, strb}, 32'd0);
    chk("good_pulse_ok",   {31'd0, chk_ok}, 32'd0);
    chk("good_hold_data",  {24'd0, received_data}, 32'h03);

    // bad checksum
    header(16'h0003, 16'h0007);
    pay("bad_b1", 8'h01, 1'b0, 1'b0, 1'b0);
    pay("bad_b2", 8'h02, 1'b0, 1'b0, 1'b0);
    pay("bad_b3", 8'h03, 1'b1, 1'b0, 1'b1);
    chk("bad_hdr",  {16'd0, header_image_data_checksum}, 32'h0007);
    chk("bad_fcnt", {16'd0, frame_cnt}, 32'd1);
    chk("bad_ecnt", {16'd0, err_cnt}, 32'd1);

    // zero length, then immediate good frame
    dr_mark = dr_seen;
    send(8'hA5); send(8'h5A); send(8'h00); send(8'h00);
    chk("len0_err",  {31'd0, chk_err}, 32'd1);
    chk("len0_ecnt", {16'd0, err_cnt}, 32'd2);
    chk("len0_hdr",  {16'd0, header_image_data_checksum}, 32'h0007);
    good_frame("len0_resync");
    chk("len0_resync_fcnt", {16'd0, frame_cnt}, 32'd2);
    chk("len0_drcnt", dr_seen - dr_mark, 32'd3);

    // MAX_LEN+1, stray bytes, then single-byte frame
    dr_mark = dr_seen;
    send(8'hA5); send(8'h5A); send(8'h10); send(8'h01);
    chk("lenmax1_err",  {31'd0, chk_err}, 32'd1);
    chk("lenmax1_ecnt", {16'd0, err_cnt}, 32'd3);
    send(8'h01); send(8'h02);
    chk("lenmax1_err_single", {31'd0, chk_err}, 32'd0);
    chk("lenmax1_no_rdy", dr_seen - dr_mark, 32'd0);
    header(16'h0001, 16'h00FF);
    pay("len1_b1", 8'hFF, 1'b1, 1'b1, 1'b0);
    chk("len1_fcnt", {16'd0, frame_cnt}, 32'd3);

    // exactly MAX_LEN bytes: 16 x (0..255) sums to 0xF800
    dr_mark = dr_seen;
    header(16'd4096, 16'hF800);
    for (int i = 0; i < 4095; i++) send(8'(i));
    pay("lenmax_last", 8'hFF, 1'b1, 1'b1, 1'b0);
    chk("lenmax_drcnt", dr_seen - dr_mark, 32'd4096);
    chk("lenmax_fcnt", {16'd0, frame_cnt}, 32'd4);

    // A5 A5 5A locks; sync bytes inside payload are data
    send(8'hA5); send(8'hA5); send(8'h5A);
    send(8'h00); send(8'h02); send(8'h00); send(8'hFF);
    pay("sync_b1", 8'hA5, 1'b0, 1'b0, 1'b0);
    pay("sync_b2", 8'h5A, 1'b1, 1'b1, 1'b0);
    chk("sync_fcnt", {16'd0, frame_cnt}, 32'd5);

    // A5 00 5A does not lock
    dr_mark = dr_seen;
    send(8'hA5); send(8'h00); send(8'h5A);
    send(8'h00); send(8'h03); send(8'h00); send(8'h06);
    send(8'h01); send(8'h02); send(8'h03);
    chk("nolock_drcnt", dr_seen - dr_mark, 32'd0);
    chk("nolock_fcnt", {16'd0, frame_cnt}, 32'd5);
    chk("nolock_ecnt", {16'd0, err_cnt}, 32'd3);

    // in_valid gaps mid-payload, then reset mid-payload
    header(16'h0004, 16'h000A);
    pay("gap_b1", 8'h01, 1'b0, 1'b0, 1'b0);
    pay("gap_b2", 8'h02, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("gap_rdy",  {31'd0, dataRdy}, 32'd0);
    chk("gap_data", {24'd0, received_data}, 32'h02);
    pay("gap_b3", 8'h03, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    send(8'h04);
    chk("midrst_ignored_rdy", {31'd0, dataRdy}, 32'd0);
    good_frame("postrst");
    chk("postrst_fcnt", {16'd0, frame_cnt}, 32'd1);
    chk("postrst_ecnt", {16'd0, err_cnt}, 32'd0);
    chk("postrst_hdr",  {16'd0, header_image_data_checksum}, 32'h0006);

`ifdef DEFRAMER_TIMEOUT_EN
    header(16'h0003, 16'h0006);
    pay("to_b1", 8'h01, 1'b0, 1'b0, 1'b0);
    idle(1023);
    chk("to_early_err", {31'd0, chk_err}, 32'd0);
    idle(1);
    chk("to_err",  {31'd0, chk_err}, 32'd1);
    chk("to_strb", {31'd0, strb}, 32'd0);
    chk("to_ecnt", {16'd0, err_cnt}, 32'd1);
    good_frame("to_resync");
    chk("to_resync_fcnt", {16'd0, frame_cnt}, 32'd2);
`endif

    chk("hdr_bytes_sent", hdr_sent > 0, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
